// File: rtl/seq_comp_unit_pkg.sv
// Shared encodings for the sequential complement unit.
// Mode codes are also used by the ALU control logic.
package seq_comp_unit_pkg;

  typedef enum logic [1:0] {
    MODE_ONES = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_ABS  = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/seq_comp_unit_chunk.sv
// One CHUNK-bit slice of the complementer.
// Optionally inverts the slice, then adds the incoming ripple carry.
module seq_comp_unit_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] in,
  input  logic             invert,
  input  logic             carry_in,
  output logic [CHUNK-1:0] out,
  output logic             carry_out
);

  logic [CHUNK-1:0] src;

  always_comb begin
    src = invert ? ~in : in;
    {carry_out, out} = {1'b0, src} + {{CHUNK{1'b0}}, carry_in};
  end

endmodule

// File: rtl/seq_comp_unit.sv
// Multi-cycle ones/two's complement, absolute value and pass-through unit.
// Processes CHUNK bits per cycle LSB first, carrying between chunks.
module seq_comp_unit
  import seq_comp_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] operand,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("seq_comp_unit: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             inv_q, inv_d;
  logic             carry_q, carry_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] chunk_in;
  logic [CHUNK-1:0] chunk_out;
  logic             chunk_cout;
  logic [WIDTH-1:0] result_ins;
  mode_e            mode_in;
  logic             neg_in;

  always_comb begin
    chunk_in = opnd_q[cnt_q * CHUNK +: CHUNK];
  end

  seq_comp_unit_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .in        (chunk_in),
    .invert    (inv_q),
    .carry_in  (carry_q),
    .out       (chunk_out),
    .carry_out (chunk_cout)
  );

  always_comb begin
    result_ins = result_q;
    result_ins[cnt_q * CHUNK +: CHUNK] = chunk_out;
  end

  always_comb begin
    mode_in    = mode_e'(mode);
    neg_in     = operand[WIDTH-1];
    state_d    = state_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    result_d   = result_q;
    inv_d      = inv_q;
    carry_d    = carry_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          opnd_d     = operand;
          cnt_d      = '0;
          carry_d    = (mode_in == MODE_NEG) || (mode_in == MODE_ABS && neg_in);
          inv_d      = (mode_in == MODE_ONES) || (mode_in == MODE_NEG) ||
                       (mode_in == MODE_ABS && neg_in);
          // Only the most-negative value cannot be negated in range.
          ovf_pend_d = ((mode_in == MODE_NEG) || (mode_in == MODE_ABS)) &&
                       (operand == {1'b1, {(WIDTH-1){1'b0}}});
          state_d    = StBusy;
        end
      end
      StBusy: begin
        result_d = result_ins;
        carry_d  = chunk_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          ovf_d   = ovf_pend_q;
          zero_d  = (result_ins == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      opnd_q     <= '0;
      result_q   <= '0;
      inv_q      <= 1'b0;
      carry_q    <= 1'b0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      result_q   <= result_d;
      inv_q      <= inv_d;
      carry_q    <= carry_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !reset;
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_comp_unit.sv
// Randomized self-checking bench for seq_comp_unit (8/4 and 16/1 configurations)
// against an arithmetic reference model.
module tb_seq_comp_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]  operand8, result8;
  logic [1:0]  mode8;
  logic        in_valid8, in_ready8, overflow8, zero8, out_valid8, out_ready8;

  logic [15:0] operand16, result16;
  logic [1:0]  mode16;
  logic        in_valid16, in_ready16, overflow16, zero16, out_valid16, out_ready16;

  int total = 0;
  int bad   = 0;

  seq_comp_unit #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .operand   (operand8),
    .mode      (mode8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .result    (result8),
    .overflow  (overflow8),
    .zero      (zero8),
    .out_valid (out_valid8),
    .out_ready (out_ready8)
  );

  seq_comp_unit #(.WIDTH(16), .CHUNK(1)) dut16 (
    .clk       (clk),
    .reset     (reset),
    .operand   (operand16),
    .mode      (mode16),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .result    (result16),
    .overflow  (overflow16),
    .zero      (zero16),
    .out_valid (out_valid16),
    .out_ready (out_ready16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic modulo 2^w.
  function automatic longint ref_result(input longint x, input int md, input int w);
    longint mask = (64'sd1 <<< w) - 1;
    longint r;
    case (md)
      0:       r = ~x & mask;
      1:       r = (-x) & mask;
      2:       r = x[w-1] ? ((-x) & mask) : x;
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic bit ref_ovf(input longint x, input int md, input int w);
    return (md == 1 || md == 2) && (x == (64'sd1 <<< (w - 1)));
  endfunction

  task automatic op8(input logic [7:0] op, input logic [1:0] md, input int stall);
    int lat;
    longint exp_r;
    logic [7:0] got_r;
    logic got_o, got_z;
    exp_r = ref_result(longint'(op), int'(md), 8);
    @(negedge clk);
    operand8 = op; mode8 = md; in_valid8 = 1'b1; out_ready8 = 1'b0;
    check("in_ready_idle", 32'(in_ready8), 32'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency8", 32'(lat), 32'd2);
    check("result8", 32'(result8), 32'(exp_r));
    check("overflow8", 32'(overflow8), 32'(ref_ovf(longint'(op), int'(md), 8)));
    check("zero8", 32'(zero8), 32'(exp_r == 0));
    got_r = result8; got_o = overflow8; got_z = zero8;
    // Backpressure with a competing request that must be ignored.
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid8 = 1'b1; operand8 = 8'($urandom); mode8 = 2'($urandom);
      check("in_ready_done", 32'(in_ready8), 32'd0);
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid8), 32'd1);
      check("hold_result", 32'(result8), 32'(got_r));
      check("hold_flags", {30'd0, overflow8, zero8}, {30'd0, got_o, got_z});
    end
    @(negedge clk);
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(posedge clk); #1;
    check("drain_valid", 32'(out_valid8), 32'd0);
    check("drain_flags", {30'd0, overflow8, zero8}, 32'd0);
    out_ready8 = 1'b0;
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    operand8 = '0; mode8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b0;
    operand16 = '0; mode16 = '0; in_valid16 = 1'b0; out_ready16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid8), 32'd0);
    check("rst_result", 32'(result8), 32'd0);
    check("rst_flags", {30'd0, overflow8, zero8}, 32'd0);
    check("rst_in_ready", 32'(in_ready8), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed corner cases.
    op8(8'h05, 2'b01, 0);
    op8(8'h80, 2'b01, 0);
    op8(8'h80, 2'b10, 0);
    op8(8'h80, 2'b11, 0);
    op8(8'hFF, 2'b00, 0);
    op8(8'h00, 2'b01, 0);
    op8(8'hF6, 2'b10, 0);
    op8(8'h0A, 2'b10, 0);
    op8(8'h01, 2'b01, 5);

    // Randomized operations with random backpressure.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] v;
      v = (n % 8 == 0) ? 8'h80 : 8'($urandom);
      op8(v, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset on the first BUSY edge discards the operation.
    @(negedge clk);
    operand8 = 8'h05; mode8 = 2'b01; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", 32'(out_valid8), 32'd0);
    check("midrst_result", 32'(result8), 32'd0);
    check("midrst_in_ready", 32'(in_ready8), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("midrst_no_valid", 32'(out_valid8), 32'd0);
    end
    check("midrst_idle", 32'(in_ready8), 32'd1);
    op8(8'h0A, 2'b01, 1);

    // 16-bit, 1-bit-per-cycle configuration.
    @(negedge clk);
    operand16 = 16'h0001; mode16 = 2'b01; in_valid16 = 1'b1; out_ready16 = 1'b0;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency16", 32'(lat), 32'd16);
    check("result16", 32'(result16), 32'(ref_result(64'd1, 1, 16)));
    check("overflow16", 32'(overflow16), 32'd0);
    @(negedge clk);
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    check("drain16", 32'(out_valid16), 32'd0);
    @(negedge clk);
    out_ready16 = 1'b0;
    operand16 = 16'h8000; mode16 = 2'b10; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("result16_abs", 32'(result16), 32'(ref_result(64'h8000, 2, 16)));
    check("overflow16_abs", 32'(overflow16), 32'(ref_ovf(64'h8000, 2, 16)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
